// File: rtl/int_group_accumulator.sv
// int_group_accumulator
//   Buffers signed 32-bit values from a blocking producer port in a small
//   FIFO, sums each run of GROUP consecutive values and offers every sum on
//   a registered blocking write port.
//
//   Optional build macro: INT_GROUP_ACC_SATURATE_EN
//     defined   -> every accumulate step clamps to 0x7FFFFFFF / 0x80000000
//     undefined -> sum wraps two's-complement
//
// Ports
//   clk            in   clock, all state on rising edge
//   rst            in   asynchronous active-low reset
//   b_in           in   signed input word
//   b_in_sync      in   producer has valid b_in
//   b_in_notify    out  FIFO has room (level < DEPTH)
//   sum_out        out  signed group sum, held until transferred
//   sum_out_sync   in   consumer ready
//   sum_out_notify out  sum_out valid
//   fifo_level     out  current FIFO occupancy
module int_group_accumulator #(
  parameter int DEPTH = 4,
  parameter int GROUP = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [31:0]         b_in,
  input  logic                       b_in_sync,
  output logic                       b_in_notify,
  output logic signed [31:0]         sum_out,
  input  logic                       sum_out_sync,
  output logic                       sum_out_notify,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0] LAST_CNT = 8'(GROUP - 1);

  typedef enum logic {ACC, SEND} state_t;

  state_t                   r_state, w_state_nxt;
  logic signed [31:0]       r_mem [DEPTH];
  logic [AW-1:0]            r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]            r_level;
  logic signed [31:0]       r_acc;
  logic [7:0]               r_cnt;
  logic signed [31:0]       r_sum;
  logic                     r_notify;

  logic                     w_push, w_pop, w_last, w_xfer;
  logic signed [31:0]       w_head, w_sum;
  logic signed [32:0]       w_sum33;

  assign b_in_notify    = (r_level < LW'(DEPTH));
  assign fifo_level     = r_level;
  assign sum_out        = r_sum;
  assign sum_out_notify = r_notify;

  always_comb begin
    w_push  = b_in_notify & b_in_sync;
    w_pop   = (r_state == ACC) && (r_level != '0);
    w_head  = r_mem[r_rd_ptr];
    w_last  = (r_cnt == LAST_CNT);
    w_xfer  = r_notify & sum_out_sync;
    // 33-bit add cannot itself overflow; bit 32 vs bit 31 flags 32-bit overflow
    w_sum33 = {r_acc[31], r_acc} + {w_head[31], w_head};
`ifdef INT_GROUP_ACC_SATURATE_EN
    if (w_sum33[32] != w_sum33[31])
      w_sum = w_sum33[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    else
      w_sum = w_sum33[31:0];
`else
    w_sum = w_sum33[31:0];
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC:  if (w_pop && w_last) w_state_nxt = SEND;
      SEND: if (w_xfer)          w_state_nxt = ACC;
      default:                   w_state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ACC;
    else      r_state <= w_state_nxt;
  end

  // Storage needs no reset: reset empties the FIFO through the level/pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= b_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_notify <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase

      if (w_pop) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 8'd1;
        if (w_last) begin
          r_sum    <= w_sum;
          r_notify <= 1'b1;
        end
      end

      if ((r_state == SEND) && w_xfer) begin
        r_notify <= 1'b0;
        r_acc    <= '0;
        r_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_int_group_accumulator.sv
module tb_int_group_accumulator;
  localparam int DEPTH = 4;
  localparam int GROUP = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [31:0] b_in = '0;
  logic               b_in_sync = 1'b0;
  logic               b_in_notify;
  logic signed [31:0] sum_out;
  logic               sum_out_sync = 1'b1;
  logic               sum_out_notify;
  logic [$clog2(DEPTH):0] fifo_level;

  int_group_accumulator #(.DEPTH(DEPTH), .GROUP(GROUP)) dut (
    .clk(clk), .rst(rst),
    .b_in(b_in), .b_in_sync(b_in_sync), .b_in_notify(b_in_notify),
    .sum_out(sum_out), .sum_out_sync(sum_out_sync), .sum_out_notify(sum_out_notify),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int m_acc = 0;
  int m_cnt = 0;
  int notify_cycles = 0;
  bit rnd_done;

  // reference: one accumulate step, straight from the arithmetic rule
  function automatic int step(int a, int b);
    longint s;
    s = longint'(a) + longint'(b);
`ifdef INT_GROUP_ACC_SATURATE_EN
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return int'(s);
`else
    return int'(s);
`endif
  endfunction

  function automatic void model_push(int v);
    m_acc = step(m_acc, v);
    m_cnt++;
    if (m_cnt == GROUP) begin
      exp_q.push_back(m_acc);
      m_acc = 0;
      m_cnt = 0;
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_acc = 0;
    m_cnt = 0;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // input-side monitor: an accepted word enters the reference model
  always @(negedge clk)
    if (rst && b_in_notify && b_in_sync) model_push(b_in);

  // output-side monitor: every transfer is checked against the queue head
  always @(negedge clk)
    if (rst && sum_out_notify) begin
      notify_cycles++;
      if (sum_out_sync) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_sum: got %0d expected none at %0t", sum_out, $time);
        end else
          chk("group_sum", sum_out, exp_q.pop_front());
      end
    end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_val(int v);
    int k;
    k = 0;
    b_in = v;
    b_in_sync = 1'b1;
    forever begin
      @(negedge clk);
      if (b_in_notify) break;
      k++;
      if (k > 200) begin
        chk("push_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    b_in_sync = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_outstanding", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_notify"},    sum_out_notify, 0);
    chk({tag, "_in_notify"}, b_in_notify, 1);
    chk({tag, "_level"},     fifo_level, 0);
    chk({tag, "_sum"},       sum_out, 0);
  endtask

  function automatic int rnd_val();
    case ($urandom_range(0, 3))
      0:       return int'($urandom);
      1:       return 32'h7FFF_0000 + int'($urandom_range(0, 32'h1_0000));
      2:       return 32'h8000_0000 + int'($urandom_range(0, 32'h1_0000));
      default: return int'($urandom_range(0, 200)) - 100;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset at an arbitrary, non-edge time
    #2 rst = 1'b0;
    model_reset();
    #1 check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);

    // basic groups with the consumer always ready
    sum_out_sync  = 1'b1;
    notify_cycles = 0;
    for (int i = 1; i <= 8; i++) push_val(i);
    drain();
    idle(2);
    chk("basic_notify_cycles", notify_cycles, 2);

    // backpressure: output stalls, FIFO fills, producer is held off
    sum_out_sync = 1'b0;
    fork
      for (int i = 0; i < 12; i++) push_val(1);
      begin
        idle(30);
        chk("bp_sum",       sum_out, 4);
        chk("bp_notify",    sum_out_notify, 1);
        chk("bp_level",     fifo_level, DEPTH);
        chk("bp_in_notify", b_in_notify, 0);
        sum_out_sync = 1'b1;
      end
    join
    drain();
    idle(2);
    chk("bp_level_empty", fifo_level, 0);

    // overflow in both directions
    push_val(32'h7FFF_FFFF); push_val(1); push_val(0); push_val(0);
    push_val(32'h8000_0000); push_val(32'hFFFF_FFFF); push_val(0); push_val(0);
    drain();

    // simultaneous push and pop at level 3 in ACC
    sum_out_sync = 1'b0;
    for (int i = 1; i <= 4; i++) push_val(i * 10);
    for (int i = 1; i <= 3; i++) push_val(i);
    idle(2);
    chk("pp_level_send", fifo_level, 3);
    sum_out_sync = 1'b1;
    @(posedge clk); #1;
    chk("pp_level_acc", fifo_level, 3);
    b_in = 4;
    b_in_sync = 1'b1;
    @(posedge clk); #1;
    b_in_sync = 1'b0;
    chk("pp_level_both", fifo_level, 3);
    for (int i = 5; i <= 8; i++) push_val(i);
    drain();
    idle(2);
    chk("pp_level_empty", fifo_level, 0);

    // asynchronous reset while a sum is waiting and two values are buffered
    sum_out_sync = 1'b0;
    for (int i = 0; i < 6; i++) push_val(9);
    idle(3);
    chk("rs_notify_before", sum_out_notify, 1);
    chk("rs_level_before",  fifo_level, 2);
    #2 rst = 1'b0;
    model_reset();
    #1 check_reset_outputs("rs_async");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    sum_out_sync = 1'b1;
    for (int i = 0; i < 4; i++) push_val(2);
    drain();

    // randomized traffic with random output backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          push_val(rnd_val());
        end
        while (m_cnt != 0) push_val(0);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          sum_out_sync = ($urandom_range(0, 2) != 0);
        end
        sum_out_sync = 1'b1;
      end
    join
    drain();
    idle(2);
    chk("rnd_level_empty", fifo_level, 0);
    chk("rnd_notify_low",  sum_out_notify, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
